serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder with carry-in. It is the sequential consumer stage for the codebase's half-adder cell.
- Each clock it adds one operand bit pair LSB-first through a full-adder slice. The slice is built from two halfadder instances. A carry flip-flop links successive bits.
- Start/busy/done handshake; the result registers hold their value until the next completion.
- Used wherever area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/halfadder.sv | 12 +
 rtl/serial_adder_fa_slice.sv | 31 +++
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    localparam int unsigned STATE_W = 2;

    // Binary state encoding, also visible to anything importing this package
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width: ceil(log2(width)), never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/halfadder.sv
// Half-adder cell: sum and carry of two single bits.
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_fa_slice.sv
// Combinational full-adder slice built from two half-adders and an OR.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    halfadder u_ha1 (
        .a (s0),
        .b (ci),
        .s (s),
        .c (c1)
    );

    // Carries from the two half-adders are never both set, so OR gives the majority
    assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with carry-in; one operand bit pair per clock, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-1:0]   sh_q;
    logic [WIDTH-1:0]   sh_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               co_q;
    logic               fa_s;
    logic               fa_c;
    logic               last_bit;

    fa_slice u_fa (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_c)
    );

    // Sum shift register after inserting the current bit at the MSB
    assign sh_d     = (sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // FSM, operand/sum shift registers, carry, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        sa_q    <= a;
                        sb_q    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        sh_q    <= '0;
                    end
                end
                RUN: begin
                    sh_q    <= sh_d;
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= sh_d;
                        co_q    <= fa_c;
                    end
                end
                DONE: begin
                    // A start here reloads immediately for back-to-back operation
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        sa_q    <= a;
                        sb_q    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        sh_q    <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       co8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       co1;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] held8;
    logic [1:0] held1;

    int pass_cnt;
    int total_cnt;
    int cyc;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .co    (co8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .co    (co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pulse start for one accepted edge and record the expected result
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8     = a;
        b8     = b;
        cin8   = c;
        start8 = 1'b1;
        q8.push_back(9'(a) + 9'(b) + 9'(c));
        tick();
        start8 = 1'b0;
    endtask

    task automatic launch1(input logic a, input logic b, input logic c);
        a1     = a;
        b1     = b;
        cin1   = c;
        start1 = 1'b1;
        q1.push_back(2'(a) + 2'(b) + 2'(c));
        tick();
        start1 = 1'b0;
    endtask

    // Wait (bounded) for done, checking held outputs on the way, then score the result
    task automatic wait8(input string tag, output int at, output int n, output int bc);
        int viol;
        logic [8:0] e;
        viol = 0;
        n    = 0;
        bc   = 0;
        while (!done8 && n < 40) begin
            if (sum8 !== held8[7:0] || co8 !== held8[8]) viol++;
            if (busy8) bc++;
            tick();
            n++;
        end
        at = cyc;
        chk({tag, "_done_seen"}, int'(done8), 1);
        chk({tag, "_hold"}, viol, 0);
        if (done8 && q8.size() > 0) begin
            e = q8.pop_front();
            chk({tag, "_sum"}, int'(sum8), int'(e[7:0]));
            chk({tag, "_co"}, int'(co8), int'(e[8]));
            chk({tag, "_busy_at_done"}, int'(busy8), 0);
            held8 = e;
        end
    endtask

    task automatic wait1(input string tag, output int n);
        logic [1:0] e;
        n = 0;
        while (!done1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, int'(done1), 1);
        if (done1 && q1.size() > 0) begin
            e = q1.pop_front();
            chk({tag, "_sumco"}, int'({co1, sum1}), int'(e));
            held1 = e;
        end
    endtask

    initial begin
        int at1;
        int at2;
        int n;
        int bc;
        int dcnt;

        pass_cnt  = 0;
        total_cnt = 0;
        cyc       = 0;
        held8     = '0;
        held1     = '0;
        rst       = 1'b1;
        start8    = 1'b0;
        a8        = '0;
        b8        = '0;
        cin8      = 1'b0;
        start1    = 1'b0;
        a1        = '0;
        b1        = '0;
        cin1      = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", int'(busy8), 0);
        chk("rst_done", int'(done8), 0);
        chk("rst_sum", int'(sum8), 0);
        chk("rst_co", int'(co8), 0);
        chk("rst_w1_busy", int'(busy1), 0);

        // 1: basic add, latency and busy window
        launch8(8'h35, 8'h4A, 1'b0);
        chk("t1_busy_start", int'(busy8), 1);
        wait8("t1", at1, n, bc);
        chk("t1_latency", n, 8);
        chk("t1_busy_cycles", bc, 8);
        tick();
        chk("t1_done_one_cycle", int'(done8), 0);

        // 2: carry-out cases, previous result held meanwhile
        launch8(8'hFF, 8'h01, 1'b0);
        wait8("t2a", at1, n, bc);
        launch8(8'hFF, 8'hFF, 1'b1);
        wait8("t2b", at1, n, bc);
        tick();

        // 3: start during RUN is ignored
        launch8(8'h10, 8'h20, 1'b0);
        tick();
        tick();
        a8     = 8'hAA;
        b8     = 8'h55;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait8("t3", at1, n, bc);
        chk("t3_latency", n + 3, 8);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dcnt++;
        end
        chk("t3_extra_done", dcnt, 0);

        // 4: back-to-back with start held high
        a8     = 8'h01;
        b8     = 8'h01;
        cin8   = 1'b0;
        start8 = 1'b1;
        q8.push_back(9'h002);
        tick();
        a8 = 8'h80;
        b8 = 8'h80;
        q8.push_back(9'h100);
        wait8("t4a", at1, n, bc);
        tick();
        start8 = 1'b0;
        wait8("t4b", at2, n, bc);
        chk("t4_done_spacing", at2 - at1, 9);
        tick();

        // 5: reset mid-operation abandons the addition
        a8     = 8'hF0;
        b8     = 8'h0F;
        cin8   = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_busy_before_rst", int'(busy8), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        held8 = '0;
        held1 = '0;
        chk("t5_busy", int'(busy8), 0);
        chk("t5_done", int'(done8), 0);
        chk("t5_sum", int'(sum8), 0);
        chk("t5_co", int'(co8), 0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dcnt++;
        end
        chk("t5_no_done", dcnt, 0);
        launch8(8'h12, 8'h34, 1'b1);
        wait8("t5_fresh", at1, n, bc);
        chk("t5_fresh_latency", n, 8);

        // 6: WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            launch1(v[0], v[1], v[2]);
            wait1("t6", n);
            chk("t6_latency", n, 1);
        end
        tick();
        chk("t6_done_clear", int'(done1), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
